// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter: fixed CPU priority, IO anti-starvation
// counter, lock-based multi-cycle ownership and 1-cycle read-valid tagging.
module mem_port_arbiter #(
  parameter int unsigned           WIDTH        = 16,
  parameter int unsigned           ADDR_WIDTH   = 16,
  parameter int unsigned           STARVE_LIMIT = 4,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE      = 16'hCFFD
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_lock,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_adr,
  input  logic [WIDTH-1:0]      cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  input  logic                  io_req,
  input  logic                  io_lock,
  input  logic                  io_we,
  input  logic [ADDR_WIDTH-1:0] io_adr,
  input  logic [WIDTH-1:0]      io_wdata,
  output logic                  io_gnt,
  output logic                  io_rvalid,
  output logic                  io_err,
  output logic [ADDR_WIDTH-1:0] mem_adr,
  output logic [WIDTH-1:0]      mem_wdata,
  output logic                  mem_we,
  input  logic [WIDTH-1:0]      mem_rdata_in,
  output logic [WIDTH-1:0]      mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_CPU = 2'd1,
    OWN_IO  = 2'd2
  } owner_t;

  localparam logic [3:0] LP_STARVE = 4'(STARVE_LIMIT);

  owner_t     r_owner;
  owner_t     w_owner_nxt;
  logic [3:0] r_wait;
  logic [1:0] r_rv;
  logic       r_err;

  logic       w_cpu_gnt;
  logic       w_io_gnt;
  logic       w_io_blocked;
  logic       w_starved;

  assign w_starved = (r_wait >= LP_STARVE);

  // Grant decision; an owner whose request has dropped falls back to the
  // IDLE rules within the same cycle, so release costs no dead cycle.
  always_comb begin
    w_cpu_gnt   = 1'b0;
    w_io_gnt    = 1'b0;
    w_owner_nxt = IDLE;
    if (reset) begin
      if (r_owner == OWN_CPU && cpu_req) begin
        w_cpu_gnt = 1'b1;
      end else if (r_owner == OWN_IO && io_req) begin
        w_io_gnt = 1'b1;
      end else if (cpu_req && io_req) begin
        if (w_starved) w_io_gnt  = 1'b1;
        else           w_cpu_gnt = 1'b1;
      end else if (cpu_req) begin
        w_cpu_gnt = 1'b1;
      end else if (io_req) begin
        w_io_gnt = 1'b1;
      end

      if (w_cpu_gnt && cpu_lock)     w_owner_nxt = OWN_CPU;
      else if (w_io_gnt && io_lock)  w_owner_nxt = OWN_IO;
    end
  end

  assign w_io_blocked = w_io_gnt & io_we & (io_adr < IO_BASE);

  always_comb begin
    mem_adr   = cpu_adr;
    mem_wdata = cpu_wdata;
    mem_we    = 1'b0;
    if (w_io_gnt) begin
      mem_adr   = io_adr;
      mem_wdata = io_wdata;
      mem_we    = io_we & ~w_io_blocked;
    end else if (w_cpu_gnt) begin
      mem_we    = cpu_we;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner <= IDLE;
      r_wait  <= '0;
      r_rv    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_owner <= w_owner_nxt;
      r_rv    <= {w_io_gnt & ~io_we, w_cpu_gnt & ~cpu_we};
      r_err   <= w_io_blocked;
      if (io_req && !w_io_gnt) begin
        if (r_wait != 4'hF) r_wait <= r_wait + 4'd1;
      end else begin
        r_wait <= '0;
      end
    end
  end

  assign cpu_gnt    = w_cpu_gnt;
  assign io_gnt     = w_io_gnt;
  assign cpu_rvalid = r_rv[0];
  assign io_rvalid  = r_rv[1];
  assign io_err     = r_err;
  assign mem_rdata  = mem_rdata_in;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a synchronous-read RAM model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_lock, cpu_we;
  logic [15:0] cpu_adr, cpu_wdata;
  logic        cpu_gnt, cpu_rvalid;
  logic        io_req, io_lock, io_we;
  logic [15:0] io_adr, io_wdata;
  logic        io_gnt, io_rvalid, io_err;
  logic [15:0] mem_adr, mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata_in, mem_rdata;

  logic [15:0] ram [0:65535];

  int n_total = 0;
  int n_pass  = 0;

  mem_port_arbiter #(
    .WIDTH(16), .ADDR_WIDTH(16), .STARVE_LIMIT(4), .IO_BASE(16'hCFFD)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_lock(cpu_lock), .cpu_we(cpu_we),
    .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .io_req(io_req), .io_lock(io_lock), .io_we(io_we),
    .io_adr(io_adr), .io_wdata(io_wdata),
    .io_gnt(io_gnt), .io_rvalid(io_rvalid), .io_err(io_err),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata_in(mem_rdata_in), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_adr] <= mem_wdata;
    mem_rdata_in <= ram[mem_adr];
  end

  typedef struct packed {
    logic        rst, creq, clk_, cwe;
    logic [15:0] cadr, cwd;
    logic        ireq, ilk, iwe;
    logic [15:0] iadr, iwd;
    logic        cg, ig, mwe, ca;
    logic [15:0] adr;
    logic        crv, irv, err, cr;
    logic [15:0] rd;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
  endtask

  task automatic apply(input vec_t t);
    reset     = t.rst;
    cpu_req   = t.creq;  cpu_lock = t.clk_; cpu_we = t.cwe;
    cpu_adr   = t.cadr;  cpu_wdata = t.cwd;
    io_req    = t.ireq;  io_lock  = t.ilk;  io_we  = t.iwe;
    io_adr    = t.iadr;  io_wdata = t.iwd;
  endtask

  task automatic drive(input logic r, input logic cq, input logic cl, input logic [15:0] ca,
                       input logic iq, input logic il, input logic [15:0] ia);
    reset = r; cpu_req = cq; cpu_lock = cl; cpu_we = 1'b0; cpu_adr = ca; cpu_wdata = '0;
    io_req = iq; io_lock = il; io_we = 1'b0; io_adr = ia; io_wdata = '0;
  endtask

  initial begin
    for (int unsigned a = 0; a < 65536; a++) ram[a] = 16'h0000;
    ram[16'h0100] = 16'h1111;
    ram[16'h0200] = 16'h2222;
    ram[16'hD000] = 16'hD0D0;
    ram[16'h1000] = 16'h1234;
    mem_rdata_in  = '0;
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);

    //                 rst creq lk  we   cadr      cwd       ireq ilk  iwe  iadr      iwd       cg   ig   mwe  ca   adr       crv  irv  err  cr   rd
    // reset with both requesting, then release: CPU granted, read lands next cycle
    vecs.push_back({1'b0,1'b1,1'b0,1'b1,16'h0100,16'hAAAA,1'b1,1'b0,1'b0,16'hD000,16'h0000,1'b0,1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b0,16'h0000});
    vecs.push_back({1'b0,1'b1,1'b0,1'b0,16'h0100,16'h0000,1'b1,1'b0,1'b0,16'hD000,16'h0000,1'b0,1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b0,16'h0000});
    vecs.push_back({1'b1,1'b1,1'b0,1'b0,16'h0100,16'h0000,1'b1,1'b0,1'b0,16'hD000,16'h0000,1'b1,1'b0,1'b0,1'b1,16'h0100,1'b0,1'b0,1'b0,1'b0,16'h0000});
    vecs.push_back({1'b1,1'b0,1'b0,1'b0,16'h0100,16'h0000,1'b0,1'b0,1'b0,16'hD000,16'h0000,1'b0,1'b0,1'b0,1'b1,16'h0100,1'b1,1'b0,1'b0,1'b1,16'h1111});
    // starvation: CPU 4 cycles, IO on the 5th, CPU resumes
    vecs.push_back({1'b1,1'b1,1'b0,1'b0,16'h0200,16'h0000,1'b1,1'b0,1'b0,16'hD000,16'h0000,1'b1,1'b0,1'b0,1'b1,16'h0200,1'b0,1'b0,1'b0,1'b0,16'h0000});
    for (int k = 0; k < 3; k++)
      vecs.push_back({1'b1,1'b1,1'b0,1'b0,16'h0200,16'h0000,1'b1,1'b0,1'b0,16'hD000,16'h0000,1'b1,1'b0,1'b0,1'b1,16'h0200,1'b1,1'b0,1'b0,1'b1,16'h2222});
    vecs.push_back({1'b1,1'b1,1'b0,1'b0,16'h0200,16'h0000,1'b1,1'b0,1'b0,16'hD000,16'h0000,1'b0,1'b1,1'b0,1'b1,16'hD000,1'b1,1'b0,1'b0,1'b1,16'h2222});
    vecs.push_back({1'b1,1'b1,1'b0,1'b0,16'h0200,16'h0000,1'b1,1'b0,1'b0,16'hD000,16'h0000,1'b1,1'b0,1'b0,1'b1,16'h0200,1'b0,1'b1,1'b0,1'b1,16'hD0D0});
    vecs.push_back({1'b1,1'b0,1'b0,1'b0,16'h0200,16'h0000,1'b0,1'b0,1'b0,16'hD000,16'h0000,1'b0,1'b0,1'b0,1'b1,16'h0200,1'b1,1'b0,1'b0,1'b1,16'h2222});
    // IO locked reads hold off the CPU; CPU granted the cycle after release
    vecs.push_back({1'b1,1'b0,1'b0,1'b0,16'h0200,16'h0000,1'b1,1'b1,1'b0,16'hD000,16'h0000,1'b0,1'b1,1'b0,1'b1,16'hD000,1'b0,1'b0,1'b0,1'b0,16'h0000});
    for (int k = 0; k < 2; k++)
      vecs.push_back({1'b1,1'b1,1'b0,1'b0,16'h0200,16'h0000,1'b1,1'b1,1'b0,16'hD000,16'h0000,1'b0,1'b1,1'b0,1'b1,16'hD000,1'b0,1'b1,1'b0,1'b1,16'hD0D0});
    vecs.push_back({1'b1,1'b1,1'b0,1'b0,16'h0200,16'h0000,1'b1,1'b0,1'b0,16'hD000,16'h0000,1'b0,1'b1,1'b0,1'b1,16'hD000,1'b0,1'b1,1'b0,1'b1,16'hD0D0});
    vecs.push_back({1'b1,1'b1,1'b0,1'b0,16'h0200,16'h0000,1'b1,1'b0,1'b0,16'hD000,16'h0000,1'b1,1'b0,1'b0,1'b1,16'h0200,1'b0,1'b1,1'b0,1'b1,16'hD0D0});
    vecs.push_back({1'b1,1'b0,1'b0,1'b0,16'h0200,16'h0000,1'b0,1'b0,1'b0,16'hD000,16'h0000,1'b0,1'b0,1'b0,1'b1,16'h0200,1'b1,1'b0,1'b0,1'b1,16'h2222});
    // blocked IO write, legal IO write, readback
    vecs.push_back({1'b1,1'b0,1'b0,1'b0,16'h0200,16'h0000,1'b1,1'b0,1'b1,16'h1000,16'h5555,1'b0,1'b1,1'b0,1'b1,16'h1000,1'b0,1'b0,1'b0,1'b0,16'h0000});
    vecs.push_back({1'b1,1'b0,1'b0,1'b0,16'h0200,16'h0000,1'b0,1'b0,1'b0,16'h1000,16'h0000,1'b0,1'b0,1'b0,1'b1,16'h0200,1'b0,1'b0,1'b1,1'b0,16'h0000});
    vecs.push_back({1'b1,1'b0,1'b0,1'b0,16'h0200,16'h0000,1'b1,1'b0,1'b1,16'hD000,16'hBEEF,1'b0,1'b1,1'b1,1'b1,16'hD000,1'b0,1'b0,1'b0,1'b0,16'h0000});
    vecs.push_back({1'b1,1'b0,1'b0,1'b0,16'h0200,16'h0000,1'b1,1'b0,1'b0,16'h1000,16'h0000,1'b0,1'b1,1'b0,1'b1,16'h1000,1'b0,1'b0,1'b0,1'b0,16'h0000});
    vecs.push_back({1'b1,1'b0,1'b0,1'b0,16'h0200,16'h0000,1'b1,1'b0,1'b0,16'hD000,16'h0000,1'b0,1'b1,1'b0,1'b1,16'hD000,1'b0,1'b1,1'b0,1'b1,16'h1234});
    // CPU write then IO read
    vecs.push_back({1'b1,1'b1,1'b0,1'b1,16'h0300,16'h7777,1'b0,1'b0,1'b0,16'hD000,16'h0000,1'b1,1'b0,1'b1,1'b1,16'h0300,1'b0,1'b1,1'b0,1'b1,16'hBEEF});
    vecs.push_back({1'b1,1'b0,1'b0,1'b0,16'h0300,16'h0000,1'b1,1'b0,1'b0,16'h0300,16'h0000,1'b0,1'b1,1'b0,1'b1,16'h0300,1'b0,1'b0,1'b0,1'b0,16'h0000});
    vecs.push_back({1'b1,1'b0,1'b0,1'b0,16'h0300,16'h0000,1'b0,1'b0,1'b0,16'h0300,16'h0000,1'b0,1'b0,1'b0,1'b1,16'h0300,1'b0,1'b1,1'b0,1'b1,16'h7777});
    // CPU lock starves IO past the limit; override applies once back at IDLE
    vecs.push_back({1'b1,1'b1,1'b1,1'b0,16'h0100,16'h0000,1'b0,1'b0,1'b0,16'hD000,16'h0000,1'b1,1'b0,1'b0,1'b1,16'h0100,1'b0,1'b0,1'b0,1'b0,16'h0000});
    for (int k = 0; k < 5; k++)
      vecs.push_back({1'b1,1'b1,1'b1,1'b0,16'h0100,16'h0000,1'b1,1'b0,1'b0,16'hD000,16'h0000,1'b1,1'b0,1'b0,1'b1,16'h0100,1'b1,1'b0,1'b0,1'b1,16'h1111});
    vecs.push_back({1'b1,1'b1,1'b0,1'b0,16'h0100,16'h0000,1'b1,1'b0,1'b0,16'hD000,16'h0000,1'b1,1'b0,1'b0,1'b1,16'h0100,1'b1,1'b0,1'b0,1'b1,16'h1111});
    vecs.push_back({1'b1,1'b1,1'b0,1'b0,16'h0100,16'h0000,1'b1,1'b0,1'b0,16'hD000,16'h0000,1'b0,1'b1,1'b0,1'b1,16'hD000,1'b1,1'b0,1'b0,1'b1,16'h1111});
    vecs.push_back({1'b1,1'b0,1'b0,1'b0,16'h0100,16'h0000,1'b0,1'b0,1'b0,16'hD000,16'h0000,1'b0,1'b0,1'b0,1'b1,16'h0100,1'b0,1'b1,1'b0,1'b1,16'hBEEF});

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      apply(vecs[i]);
      #2;
      chk("cpu_gnt",    i, {15'd0, cpu_gnt},    {15'd0, vecs[i].cg});
      chk("io_gnt",     i, {15'd0, io_gnt},     {15'd0, vecs[i].ig});
      chk("mem_we",     i, {15'd0, mem_we},     {15'd0, vecs[i].mwe});
      chk("cpu_rvalid", i, {15'd0, cpu_rvalid}, {15'd0, vecs[i].crv});
      chk("io_rvalid",  i, {15'd0, io_rvalid},  {15'd0, vecs[i].irv});
      chk("io_err",     i, {15'd0, io_err},     {15'd0, vecs[i].err});
      if (vecs[i].ca) chk("mem_adr",   i, mem_adr,   vecs[i].adr);
      if (vecs[i].cr) chk("mem_rdata", i, mem_rdata, vecs[i].rd);
    end

    // reset asserted while IO owns the port with a read in flight
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 16'h0100, 1'b1, 1'b1, 16'hD000);
    #2;
    chk("ml_io_gnt", 0, {15'd0, io_gnt}, 16'd1);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 16'h0100, 1'b1, 1'b1, 16'hD000);
    #2;
    chk("ml_io_rvalid", 1, {15'd0, io_rvalid}, 16'd0);
    chk("ml_io_gnt",    1, {15'd0, io_gnt},    16'd0);
    chk("ml_cpu_gnt",   1, {15'd0, cpu_gnt},   16'd0);
    chk("ml_mem_we",    1, {15'd0, mem_we},    16'd0);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 16'h0100, 1'b1, 1'b1, 16'hD000);
    #2;
    chk("ml_cpu_gnt", 2, {15'd0, cpu_gnt}, 16'd1);
    chk("ml_io_gnt",  2, {15'd0, io_gnt},  16'd0);
    chk("ml_mem_adr", 2, mem_adr, 16'h0100);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 16'hD000);
    #2;
    chk("ml_cpu_rvalid", 3, {15'd0, cpu_rvalid}, 16'd1);
    chk("ml_io_rvalid",  3, {15'd0, io_rvalid},  16'd0);
    chk("ml_mem_rdata",  3, mem_rdata, 16'h1111);

    @(negedge clk);
    chk("ram_1000", 0, ram[16'h1000], 16'h1234);
    chk("ram_D000", 0, ram[16'hD000], 16'hBEEF);
    chk("ram_0300", 0, ram[16'h0300], 16'h7777);
    chk("ram_0100", 0, ram[16'h0100], 16'h1111);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port (address, write data, write enable, read data) between two requesters.
- Requester 0 is the CPU's multicycle controller/datapath; requester 1 is the IO engine (UART/VGA/interrupt-control fetches in the IO_MEM region).
- The arbiter sits between the CPU top level and the synchronous-read block RAM.
- Fixed CPU priority, an anti-starvation counter for IO, and lock-based multi-cycle ownership.

Parameters:
- WIDTH, 16, data width.
- ADDR_WIDTH, 16, address width.
- STARVE_LIMIT, 4, consecutive denied IO cycles after which IO outranks CPU; legal range 1..15.
- IO_BASE, 16'hCFFD, lowest address IO may write; IO writes below it are blocked.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU requests a memory cycle.
- cpu_lock  in  1  CPU asks to keep ownership while cpu_req stays high.
- cpu_we  in  1  CPU write strobe.
- cpu_adr  in  ADDR_WIDTH  CPU address.
- cpu_wdata  in  WIDTH  CPU write data.
- cpu_gnt  out  1  CPU access accepted this cycle (combinational); when low, the CPU must stall.
- cpu_rvalid  out  1  mem_rdata holds the CPU's read result (registered).
- io_req, io_lock, io_we, io_adr, io_wdata  in  1/1/1/ADDR_WIDTH/WIDTH  same meaning for IO.
- io_gnt  out  1  IO access accepted this cycle.
- io_rvalid  out  1  mem_rdata holds the IO's read result.
- io_err  out  1  one-cycle pulse: IO write below IO_BASE was dropped.
- mem_adr  out  ADDR_WIDTH  address to RAM.
- mem_wdata  out  WIDTH  write data to RAM.
- mem_we  out  1  write enable to RAM.
- mem_rdata_in  in  WIDTH  RAM read data; valid one cycle after the address.
- mem_rdata  out  WIDTH  pass-through of mem_rdata_in.

Behaviour:
- State machine states: IDLE, OWN_CPU, OWN_IO.
  - Register owner_q: 2-bit state. Register wait_q: 4-bit IO starvation counter.
  - Register rv_q: 2-bit read-valid pipeline {io, cpu}.
  - Register err_q: 1 bit.
- Reset (reset=0, asynchronous):
  - owner_q=IDLE, wait_q=0, rv_q=0, err_q=0.
  - cpu_gnt=io_gnt=0 and mem_we=0 while reset is low.
  - mem_adr and mem_wdata are don't-care during reset.
- Grant decision, combinational, per cycle:
  - OWN_CPU with cpu_req=1 -> CPU granted, regardless of io_req or wait_q.
  - OWN_IO with io_req=1 -> IO granted.
  - Otherwise, the owner is treated as IDLE:
    - both req and wait_q>=STARVE_LIMIT -> IO granted;
    - both req, otherwise -> CPU granted;
    - single req -> that requester is granted;
    - no req -> nothing granted.
- At most one grant per cycle.
- Memory mux:
  - mem_adr, mem_wdata and mem_we come from the granted requester.
  - mem_we = granted requester's we & grant.
  - Exception: IO write with io_adr < IO_BASE is forced to mem_we=0; io_gnt is still 1 and err_q is set next cycle.
  - No grant -> mem_we=0 and mem_adr holds the CPU address.
- Next state:
  - A granted requester with its lock=1 -> owner_q = OWN_CPU or OWN_IO.
  - Otherwise -> IDLE.
  - An owner releases the cycle after it drops req or lock; no extra dead cycle.
- wait_q update:
  - +1 (saturating at 15) when io_req=1 and io_gnt=0.
  - Cleared when io_gnt=1 or io_req=0.
- Read latency is exactly 1 cycle:
  - rv_q[0] <= cpu_gnt & ~cpu_we; rv_q[1] <= io_gnt & ~io_we.
  - cpu_rvalid=rv_q[0]; io_rvalid=rv_q[1].
  - A blocked IO write produces no rvalid.
- Back-to-back grants to alternating requesters are legal. Read data is tagged only by rvalid.
- err_q is a single-cycle pulse (io_err), cleared the following cycle unless re-triggered.
- Reset asserted mid-lock: ownership is lost and any pending rvalid is dropped; after reset the requester must re-request.
- Simultaneous cases:
  - Lock holder re-requesting while the other waits keeps ownership; wait_q keeps counting. This starvation under lock is intentional.
  - Starvation override takes effect only from the IDLE decision.

Test Plan:
- Reset low with cpu_req=io_req=1 -> both gnt=0, mem_we=0. Release reset -> cpu_gnt=1 the same cycle; cpu_rvalid=1 one cycle later with mem_rdata = RAM[cpu_adr].
- cpu_req and io_req held high, no locks, STARVE_LIMIT=4 -> CPU granted 4 cycles, IO granted on the 5th cycle (wait_q=4), then wait_q=0 and CPU resumes.
- IO read 16'hD000 with io_lock=1 for 3 cycles while cpu_req=1 -> io_gnt=1 for 3 cycles, cpu_gnt=0. The cycle after io_lock drops, cpu_gnt=1. io_rvalid pulses once per IO read.
- IO write to 16'h1000 -> io_gnt=1, mem_we=0, io_err=1 the next cycle for exactly one cycle, RAM unchanged. IO write to 16'hD000 with data 16'hBEEF -> mem_we=1 and a later read returns 16'hBEEF.
- CPU write then IO read in the next cycle -> mem_we 1 then 0, cpu_rvalid stays 0, io_rvalid=1 in the third cycle.
- Assert reset while OWN_IO with a read in flight -> io_rvalid=0 and owner=IDLE immediately. After release, CPU wins an IDLE-tie.
